// File: rtl/noc_traffic_orchestrator.sv
// Multi-round NoC traffic sequencer: staggered loader starts, idle wait with watchdog,
// then a PMU register sweep streamed out one registered beat per enabled channel.
module noc_traffic_orchestrator #(
    parameter int N          = 16,
    parameter int PMU_ADDR_W = 5,
    parameter int PMU_REGS   = 8,
    parameter int PMU_LAT    = 1,
    parameter int DATA_W     = 64,
    parameter int ROUNDS_W   = 8,
    parameter int TIMEOUT_W  = 16,
    localparam int CHAN_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       go_i,
    input  logic                       abort_i,
    input  logic [N-1:0]               cfg_mask_i,
    input  logic [ROUNDS_W-1:0]        cfg_rounds_i,
    input  logic [7:0]                 cfg_stagger_i,
    input  logic [TIMEOUT_W-1:0]       cfg_timeout_i,
    output logic [N-1:0]               start_o,
    input  logic [N-1:0]               idle_i,
    output logic [PMU_ADDR_W-1:0]      pmu_addr_o,
    input  logic [N-1:0][DATA_W-1:0]   pmu_data_i,
    output logic                       snap_valid_o,
    input  logic                       snap_ready_i,
    output logic [CHAN_W-1:0]          snap_chan_o,
    output logic [PMU_ADDR_W-1:0]      snap_reg_o,
    output logic [ROUNDS_W-1:0]        snap_round_o,
    output logic [DATA_W-1:0]          snap_data_o,
    output logic                       snap_last_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o
);
    localparam int LAT_W = (PMU_LAT > 1) ? $clog2(PMU_LAT) : 1;
    localparam logic [PMU_ADDR_W-1:0] LAST_REG = PMU_ADDR_W'(PMU_REGS - 1);
    localparam logic [LAT_W-1:0]      LAT_LD   = LAT_W'(PMU_LAT - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, GUARD, WAIT, SETTLE, SNAP, DONE} state_t;

    typedef struct packed {
        logic [ROUNDS_W-1:0]   round;
        logic [CHAN_W-1:0]     chan;
        logic [PMU_ADDR_W-1:0] pmu_reg;
        logic [DATA_W-1:0]     data;
        logic                  last;
    } beat_t;

    function automatic logic has_from(input logic [N-1:0] m, input int lo);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N; i++)
            if (m[i] && i >= lo) r = 1'b1;
        return r;
    endfunction

    function automatic logic [CHAN_W-1:0] idx_from(input logic [N-1:0] m, input int lo);
        logic [CHAN_W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--)
            if (m[i] && i >= lo) r = CHAN_W'(i);
        return r;
    endfunction

    state_t                state_q, state_n;
    logic [N-1:0]          mask_q, mask_n;
    logic [ROUNDS_W-1:0]   rounds_q, rounds_n, round_q, round_n;
    logic [7:0]            stagger_q, stagger_n, cnt_q, cnt_n;
    logic [TIMEOUT_W-1:0]  tlim_q, tlim_n, wdog_q, wdog_n;
    logic [CHAN_W-1:0]     lchan_q, lchan_n, ld_chan;
    logic [LAT_W-1:0]      lat_q, lat_n;
    logic [PMU_ADDR_W-1:0] reg_q, reg_n;
    logic                  timeout_q, timeout_n, valid_q, valid_n;
    beat_t                 beat_q, beat_n, beat_ld;
    logic [TIMEOUT_W:0]    wd_inc;
    logic [ROUNDS_W:0]     round_inc;
    logic                  round_over;

    always_comb begin
        state_n   = state_q;
        mask_n    = mask_q;
        rounds_n  = rounds_q;
        stagger_n = stagger_q;
        tlim_n    = tlim_q;
        round_n   = round_q;
        lchan_n   = lchan_q;
        cnt_n     = cnt_q;
        lat_n     = lat_q;
        wdog_n    = wdog_q;
        reg_n     = reg_q;
        timeout_n = timeout_q;
        valid_n   = valid_q;
        beat_n    = beat_q;
        start_o   = '0;

        // SETTLE loads the first enabled channel, SNAP the one after the current beat
        ld_chan = (state_q == SNAP) ? idx_from(mask_q, int'(beat_q.chan) + 1)
                                    : idx_from(mask_q, 0);
        beat_ld.round   = round_q;
        beat_ld.chan    = ld_chan;
        beat_ld.pmu_reg = reg_q;
        beat_ld.data    = pmu_data_i[ld_chan];
        beat_ld.last    = (reg_q == LAST_REG) && !has_from(mask_q, int'(ld_chan) + 1);

        wd_inc     = {1'b0, wdog_q} + (TIMEOUT_W+1)'(1);
        round_inc  = {1'b0, round_q} + (ROUNDS_W+1)'(1);
        round_over = timeout_q || (round_inc == {1'b0, rounds_q});

        case (state_q)
            IDLE, DONE: begin
                if (go_i) begin
                    mask_n    = cfg_mask_i;
                    rounds_n  = (cfg_rounds_i == '0) ? ROUNDS_W'(1) : cfg_rounds_i;
                    stagger_n = cfg_stagger_i;
                    tlim_n    = cfg_timeout_i;
                    timeout_n = 1'b0;
                    round_n   = '0;
                    reg_n     = '0;
                    lchan_n   = idx_from(cfg_mask_i, 0);
                    cnt_n     = '0;
                    state_n   = (cfg_mask_i == '0) ? DONE : LAUNCH;
                end
            end
            LAUNCH: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 8'd1;
                end else if (stagger_q == '0) begin
                    start_o = mask_q;
                    cnt_n   = 8'd1;
                    state_n = GUARD;
                end else begin
                    start_o = N'(1) << lchan_q;
                    if (has_from(mask_q, int'(lchan_q) + 1)) begin
                        lchan_n = idx_from(mask_q, int'(lchan_q) + 1);
                        cnt_n   = stagger_q - 8'd1;
                    end else begin
                        cnt_n   = 8'd1;
                        state_n = GUARD;
                    end
                end
            end
            GUARD: begin
                if (cnt_q == '0) begin
                    wdog_n  = '0;
                    state_n = WAIT;
                end else begin
                    cnt_n = cnt_q - 8'd1;
                end
            end
            WAIT: begin
                if ((idle_i & mask_q) == mask_q) begin
                    lat_n   = LAT_LD;
                    state_n = SETTLE;
                end else if (tlim_q != '0 && wd_inc == {1'b0, tlim_q}) begin
                    timeout_n = 1'b1;
                    lat_n     = LAT_LD;
                    state_n   = SETTLE;
                end else if (!(&wdog_q)) begin
                    wdog_n = wd_inc[TIMEOUT_W-1:0];
                end
            end
            SETTLE: begin
                if (lat_q == '0) begin
                    beat_n  = beat_ld;
                    valid_n = 1'b1;
                    state_n = SNAP;
                end else begin
                    lat_n = lat_q - LAT_W'(1);
                end
            end
            SNAP: begin
                if (valid_q && snap_ready_i) begin
                    if (has_from(mask_q, int'(beat_q.chan) + 1)) begin
                        beat_n = beat_ld;
                    end else begin
                        valid_n = 1'b0;
                        if (reg_q != LAST_REG) begin
                            reg_n   = reg_q + PMU_ADDR_W'(1);
                            lat_n   = LAT_LD;
                            state_n = SETTLE;
                        end else begin
                            reg_n = '0;
                            if (round_over) begin
                                state_n = DONE;
                            end else begin
                                round_n = round_inc[ROUNDS_W-1:0];
                                lchan_n = idx_from(mask_q, 0);
                                cnt_n   = '0;
                                state_n = LAUNCH;
                            end
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // abort shares the reset path so every output collapses to 0 the next cycle
    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            rounds_q  <= '0;
            stagger_q <= '0;
            tlim_q    <= '0;
            round_q   <= '0;
            lchan_q   <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            wdog_q    <= '0;
            reg_q     <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_n;
            mask_q    <= mask_n;
            rounds_q  <= rounds_n;
            stagger_q <= stagger_n;
            tlim_q    <= tlim_n;
            round_q   <= round_n;
            lchan_q   <= lchan_n;
            cnt_q     <= cnt_n;
            lat_q     <= lat_n;
            wdog_q    <= wdog_n;
            reg_q     <= reg_n;
            timeout_q <= timeout_n;
            valid_q   <= valid_n;
            beat_q    <= beat_n;
        end
    end

    assign pmu_addr_o   = reg_q;
    assign snap_valid_o = valid_q;
    assign snap_chan_o  = beat_q.chan;
    assign snap_reg_o   = beat_q.pmu_reg;
    assign snap_round_o = beat_q.round;
    assign snap_data_o  = beat_q.data;
    assign snap_last_o  = beat_q.last;
    assign done_o       = (state_q == DONE);
    assign busy_o       = (state_q != IDLE) && (state_q != DONE);
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_noc_traffic_orchestrator.sv
// Scenario bench for noc_traffic_orchestrator: loader/PMU models, beat scoreboard
// with stability monitor, and one task per scenario.
module tb_noc_traffic_orchestrator;
    localparam int N = 4, AW = 5, REGS = 8, LAT = 1, DW = 64, RW = 8, TW = 16, CW = 2;

    typedef struct packed {
        logic [RW-1:0] round;
        logic [CW-1:0] chan;
        logic [AW-1:0] pmu_reg;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst, go, abort, snap_ready;
    logic [N-1:0] cfg_mask, start, idle;
    logic [RW-1:0] cfg_rounds;
    logic [7:0] cfg_stagger;
    logic [TW-1:0] cfg_timeout;
    logic [AW-1:0] pmu_addr;
    logic [N-1:0][DW-1:0] pmu_data;
    logic snap_valid, snap_last, busy, done, timeout;
    logic [CW-1:0] snap_chan;
    logic [AW-1:0] snap_reg;
    logic [RW-1:0] snap_round;
    logic [DW-1:0] snap_data;

    int checks = 0, errors = 0, cyc = 0, nbeats = 0, first_valid_cyc = -1;
    bit rand_ready = 0, hold_pending = 0;
    int busy_len [N];
    int ld_cnt [N];
    logic [N-1:0] hold_busy = '0;
    beat_t exp_q [$];
    beat_t mon_act, mon_prev, mon_exp;
    int start_cyc [$];
    logic [N-1:0] start_vec [$];

    noc_traffic_orchestrator #(.N(N), .PMU_ADDR_W(AW), .PMU_REGS(REGS), .PMU_LAT(LAT),
        .DATA_W(DW), .ROUNDS_W(RW), .TIMEOUT_W(TW)) dut (
        .clk_i(clk), .rst_i(rst), .go_i(go), .abort_i(abort),
        .cfg_mask_i(cfg_mask), .cfg_rounds_i(cfg_rounds), .cfg_stagger_i(cfg_stagger),
        .cfg_timeout_i(cfg_timeout), .start_o(start), .idle_i(idle),
        .pmu_addr_o(pmu_addr), .pmu_data_i(pmu_data),
        .snap_valid_o(snap_valid), .snap_ready_i(snap_ready),
        .snap_chan_o(snap_chan), .snap_reg_o(snap_reg), .snap_round_o(snap_round),
        .snap_data_o(snap_data), .snap_last_o(snap_last),
        .busy_o(busy), .done_o(done), .timeout_o(timeout));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pmu_val(input int c, input int a);
        logic [31:0] h;
        h = 32'(32'h9E37_79B9 * (c * 32 + a + 1));
        return {16'hC0DE, 8'(c), 8'(a), h};
    endfunction

    always_comb
        for (int c = 0; c < N; c++) pmu_data[c] = pmu_val(c, int'(pmu_addr));

    // loader model: busy for busy_len cycles after its start pulse
    always @(posedge clk)
        for (int c = 0; c < N; c++)
            if (start[c]) ld_cnt[c] <= busy_len[c];
            else if (ld_cnt[c] != 0) ld_cnt[c] <= ld_cnt[c] - 1;
    always_comb
        for (int c = 0; c < N; c++) idle[c] = (ld_cnt[c] == 0) && !hold_busy[c];

    always @(posedge clk) begin
        #1;
        snap_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // start log plus beat scoreboard and hold-stability monitor
    always @(negedge clk) begin
        if (start != '0) begin
            start_cyc.push_back(cyc);
            start_vec.push_back(start);
        end
        mon_act = '{snap_round, snap_chan, snap_reg, snap_data, snap_last};
        if (snap_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold_pending) begin
                checks++;
                if (mon_act !== mon_prev) begin
                    errors++;
                    $display("FAIL beat_stable got %h want %h", mon_act, mon_prev);
                end
            end
            if (snap_ready) begin
                nbeats++;
                hold_pending = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected got %h want none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL beat got %h want %h", mon_act, mon_exp);
                    end
                end
            end else begin
                hold_pending = 1;
                mon_prev = mon_act;
            end
        end else begin
            hold_pending = 0;
        end
    end

    task automatic push_round(input logic [N-1:0] m, input int rnd);
        int hi;
        hi = 0;
        for (int c = 0; c < N; c++) if (m[c]) hi = c;
        for (int r = 0; r < REGS; r++)
            for (int c = 0; c < N; c++)
                if (m[c]) exp_q.push_back('{RW'(rnd), CW'(c), AW'(r), pmu_val(c, r),
                                            (r == REGS - 1) && (c == hi)});
    endtask

    task automatic do_go(input logic [N-1:0] m, input int rounds, input int stg,
                         input int tmo, output int t);
        @(posedge clk); #1;
        start_cyc.delete();
        start_vec.delete();
        nbeats = 0;
        first_valid_cyc = -1;
        cfg_mask = m;
        cfg_rounds = RW'(rounds);
        cfg_stagger = 8'(stg);
        cfg_timeout = TW'(tmo);
        go = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; abort = 1'b0;
        cfg_mask = '0; cfg_rounds = '0; cfg_stagger = '0; cfg_timeout = '0;
        for (int c = 0; c < N; c++) busy_len[c] = 5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({snap_valid, busy, done, timeout, start, pmu_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {snap_valid, busy, done, timeout, start, pmu_addr});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single();
        int t;
        bit ok;
        push_round(4'b0001, 0);
        do_go(4'b0001, 1, 0, 0, t);
        wait_done(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_done got 0 want 1"); end
        checks++;
        if (start_cyc.size() != 1 || start_cyc[0] != t + 1 || start_vec[0] !== 4'b0001) begin
            errors++;
            $display("FAIL single_start got n=%0d cyc=%0d want n=1 cyc=%0d",
                     start_cyc.size(), start_cyc.size() ? start_cyc[0] - t : -1, 1);
        end
        checks++;
        if (first_valid_cyc != t + 9) begin
            errors++;
            $display("FAIL single_first_valid got T+%0d want T+9", first_valid_cyc - t);
        end
        checks++;
        if (nbeats != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_beats got %0d left %0d want 8 left 0", nbeats, exp_q.size());
        end
        checks++;
        if ({busy, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL single_status got %b want 00", {busy, timeout});
        end
    endtask

    task automatic test_stagger();
        int t;
        bit ok;
        int want_c [3] = '{1, 4, 7};
        logic [N-1:0] want_v [3] = '{4'b0001, 4'b0010, 4'b1000};
        push_round(4'b1011, 0);
        do_go(4'b1011, 1, 3, 0, t);
        wait_done(600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stagger_done got 0 want 1"); end
        checks++;
        if (start_cyc.size() != 3) begin
            errors++;
            $display("FAIL stagger_count got %0d want 3", start_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (start_cyc[k] != t + want_c[k] || start_vec[k] !== want_v[k]) begin
                    errors++;
                    $display("FAIL stagger_start%0d got T+%0d %b want T+%0d %b", k,
                             start_cyc[k] - t, start_vec[k], want_c[k], want_v[k]);
                end
            end
        end
        checks++;
        if (nbeats != 24 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stagger_beats got %0d want 24", nbeats);
        end
    endtask

    task automatic test_backpressure();
        int t;
        bit ok;
        rand_ready = 1;
        push_round(4'b1101, 0);
        do_go(4'b1101, 1, 1, 0, t);
        wait_done(2000, ok);
        rand_ready = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done got 0 want 1"); end
        checks++;
        if (nbeats != 24 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_beats got %0d left %0d want 24 left 0", nbeats, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int t;
        bit ok;
        hold_busy = 4'b0100;
        push_round(4'b0111, 0);
        do_go(4'b0111, 3, 0, 50, t);
        while (cyc != t + 53) @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got %b want 0", timeout); end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_rise got %b want 1", timeout); end
        wait_done(600, ok);
        checks++;
        if (!ok || timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_done got done=%0d tmo=%b want 1 1", ok, timeout);
        end
        checks++;
        if (nbeats != 24 || exp_q.size() != 0 || start_cyc.size() != 1) begin
            errors++;
            $display("FAIL tmo_rounds got beats=%0d starts=%0d want 24 1", nbeats, start_cyc.size());
        end
        hold_busy = '0;
    endtask

    task automatic test_multi_round();
        int t;
        bit ok;
        for (int c = 0; c < N; c++) busy_len[c] = 20;
        push_round(4'b0101, 0);
        push_round(4'b0101, 1);
        do_go(4'b0101, 2, 0, 0, t);
        while (cyc != t + 8) @(negedge clk);
        cfg_mask = 4'b1111;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        wait_done(1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL multi_done got 0 want 1"); end
        checks++;
        if (nbeats != 32 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL multi_beats got %0d want 32", nbeats);
        end
        checks++;
        if (start_cyc.size() != 2 || start_vec[0] !== 4'b0101 || start_vec[1] !== 4'b0101) begin
            errors++;
            $display("FAIL multi_starts got %0d want 2 of 0101", start_cyc.size());
        end
        for (int c = 0; c < N; c++) busy_len[c] = 5;
        do_go(4'b0000, 1, 0, 0, t);
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL zero_mask_done got %b want 10", {done, busy});
        end
        repeat (10) @(negedge clk);
        checks++;
        if (start_cyc.size() != 0 || nbeats != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_mask_quiet got starts=%0d beats=%0d want 0 0", start_cyc.size(), nbeats);
        end
    endtask

    task automatic test_abort();
        int t;
        bit ok;
        push_round(4'b1111, 0);
        do_go(4'b1111, 1, 0, 0, t);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (nbeats >= 5 && snap_valid) ok = 1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_reach_snap got 0 want 1"); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        exp_q.delete();
        checks++;
        if ({snap_valid, snap_chan, snap_reg, snap_round, snap_data, snap_last,
             start, pmu_addr, busy, done, timeout} !== '0) begin
            errors++;
            $display("FAIL abort_clear got v=%b busy=%b done=%b addr=%0d want all 0",
                     snap_valid, busy, done, pmu_addr);
        end
        push_round(4'b0011, 0);
        do_go(4'b0011, 1, 0, 0, t);
        wait_done(600, ok);
        checks++;
        if (!ok || nbeats != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_rerun got done=%0d beats=%0d want 1 16", ok, nbeats);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stagger();
        test_backpressure();
        test_timeout();
        test_multi_round();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/noc_traffic_orchestrator.md
# noc_traffic_orchestrator

Multi-round traffic sequencer and PMU snapshot collector for the NoC cosimulation harness. It drives per-channel start pulses to up to N AXI master loaders, with an optional stagger and a channel enable mask. It waits for every enabled loader to return idle, with a watchdog timeout. It then sweeps the shared PMU register address and streams every enabled channel's counter values out over a valid/ready port, repeating for a programmed number of rounds.

## Interface
Parameters:
- `N`, 16, number of loader/PMU channels (≥1).
- `PMU_ADDR_W`, 5, PMU register address width.
- `PMU_REGS`, 8, registers swept per snapshot, addresses 0..PMU_REGS-1 (1..2^PMU_ADDR_W).
- `PMU_LAT`, 1, cycles from a `pmu_addr_o` change to valid `pmu_data_i` (≥1).
- `DATA_W`, 64, PMU data width.
- `ROUNDS_W`, 8, round counter width.
- `TIMEOUT_W`, 16, watchdog width.

Ports:
- `clk_i` in 1: single clock, all logic rising-edge.
- `rst_i` in 1: synchronous, active-high reset.
- `go_i` in 1: start-run pulse, accepted only in IDLE or DONE.
- `abort_i` in 1: synchronous abort, any state → IDLE.
- `cfg_mask_i` in N: channel enable mask, sampled at go.
- `cfg_rounds_i` in ROUNDS_W: rounds to run; 0 is treated as 1; sampled at go.
- `cfg_stagger_i` in 8: cycles between successive channel starts; sampled at go.
- `cfg_timeout_i` in TIMEOUT_W: WAIT watchdog limit; 0 disables it; sampled at go.
- `start_o` out N: one-cycle start pulse per channel.
- `idle_i` in N: loader idle flags.
- `pmu_addr_o` out PMU_ADDR_W: address broadcast to all PMUs.
- `pmu_data_i` in N×DATA_W: PMU read data per channel.
- `snap_valid_o` out 1, `snap_ready_i` in 1: snapshot beat handshake.
- `snap_chan_o` out $clog2(N) (min 1), `snap_reg_o` out PMU_ADDR_W, `snap_round_o` out ROUNDS_W, `snap_data_o` out DATA_W, `snap_last_o` out 1.
- `busy_o`, `done_o`, `timeout_o` out 1: status.

## Operation
- Reset or abort clears all outputs to 0 and sets the FSM to IDLE.
- FSM states: IDLE → LAUNCH → GUARD → WAIT → SETTLE → SNAP → (LAUNCH for the next round | DONE).
- `go_i` in IDLE/DONE:
  - Latches the config.
  - Clears `done_o`/`timeout_o` and sets round = 0.
  - If the mask is all zero, goes directly to DONE; no starts and no beats are issued.
  - `go_i` in any other state is ignored.
- LAUNCH:
  - Enabled channels are started in ascending index order.
  - The k-th enabled channel (k from 0) pulses in launch cycle k×stagger.
  - With stagger 0, all enabled channels pulse in the same cycle.
  - Disabled channels never pulse.
- GUARD: 2 cycles after the last start pulse, to absorb loader idle deassertion latency.
- WAIT:
  - Completes when `(idle_i & mask) == mask`.
  - The watchdog counts WAIT cycles. Reaching cfg_timeout without completion sets the sticky `timeout_o` and proceeds to SETTLE.
  - If completion and the timeout limit fall in the same cycle, completion wins.
- SETTLE: drives `pmu_addr_o` = the current register and waits PMU_LAT cycles.
- SNAP:
  - For each enabled channel in ascending order, presents one registered beat: {round, chan, reg, data}. Data is captured from `pmu_data_i[chan]` when the beat loads.
  - A beat is held stable until `snap_valid_o && snap_ready_i`. The next beat loads the cycle after the handshake, so there are no bubbles beyond one load cycle.
  - After the last enabled channel, the register increments and the FSM returns to SETTLE.
  - After register PMU_REGS-1, the round ends. `snap_last_o` is 1 on the final beat of each round.
- Round end:
  - If `timeout_o` is set or round+1 == rounds, go to DONE.
  - Otherwise increment the round and go to LAUNCH.
- Status flags:
  - DONE: `done_o` = 1 (level until the next go, abort, or reset); `busy_o` = 0.
  - `busy_o` = 1 in every state other than IDLE/DONE.

## Timing
- `go_i` accepted at cycle T → first start pulse at T+1; with stagger 0 all pulses occur at T+1.
- Last start at cycle L → GUARD at L+1..L+2; WAIT first evaluates at L+3.
- WAIT completes at cycle W → `pmu_addr_o` = 0 at W+1 → first `snap_valid_o` at W+1+PMU_LAT.
- `pmu_addr_o` is held constant throughout SETTLE and SNAP for one register.
- `snap_*` outputs change only on reset, abort, or the cycle after a handshake.
- The watchdog has TIMEOUT_W bits and does not wrap; it resets on every WAIT entry.
- Abort in mid-SNAP drops the pending beat; `snap_valid_o` is 0 on the next cycle.

## Test plan
- **Single-channel run.** N=4, mask=0001, rounds=1, stagger=0, `snap_ready_i` = 1.
  - Required: `start_o`[0] pulses at T+1.
  - Required: after idle, exactly 8 beats with chan=0 and reg 0..7 in order; `snap_last_o` only on reg 7; `done_o` set.
- **Stagger.** mask=1011, stagger=3.
  - Required: starts on channels 0, 1, 3 at T+1, T+4, T+7.
  - Required: 24 beats, in channel order 0, 1, 3 for each register.
- **Backpressure.** `snap_ready_i` toggles at random.
  - Required: each beat's fields are stable while not accepted.
  - Required: beat count and order are unchanged; data matches the PMU model value for (chan, reg).
- **Timeout.** Channel 2 is held busy; timeout=50; rounds=3.
  - Required: `timeout_o` rises after 50 WAIT cycles.
  - Required: one full snapshot is still emitted; DONE follows after round 0 only.
- **Multi-round, all-zero mask, go while busy.**
  - Required: rounds=2 gives `snap_round_o` = 0 then 1.
  - Required: `go_i` during WAIT has no effect.
  - Required: mask=0 goes directly to `done_o` with no starts and no beats.
- **Abort.** `abort_i` asserted mid-SNAP.
  - Required: the next cycle returns to IDLE with all outputs 0.
  - Required: a subsequent go runs normally from round 0.
